// File: rtl/wait_state_seq.sv
// Wait-state sequencer: per-channel programmable wait count, external wait
// extension with timeout, and registered DSACK1/BERR cycle termination.
module wait_state_seq #(
  parameter  int unsigned CHANNELS      = 2,
  parameter  int unsigned WAIT_W        = 4,
  parameter  int unsigned DEFAULT_WAITS = 4,
  parameter  int unsigned TIMEOUT       = 255,
  localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned TMO_W         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                CLKCPU,
  input  logic                RESET,
  input  logic                AS20,
  input  logic [CHANNELS-1:0] SEL,
  input  logic                IDEWAIT,
  input  logic                CFG_WE,
  input  logic [CH_W-1:0]     CFG_CH,
  input  logic [WAIT_W-1:0]   CFG_DATA,
  output logic                DSACK1,
  output logic                BERR,
  output logic                BUSY,
  output logic [CH_W-1:0]     CH
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // HOLD cycles are counted from 0, so the last one before error is TIMEOUT-1
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              dsack_q, berr_q, busy_q;
  logic [WAIT_W-1:0] waits_q [CHANNELS];

  logic              sel_hit;
  logic [CH_W-1:0]   sel_idx;
  logic [WAIT_W-1:0] sel_wait;

  // Lowest-index asserted select wins: scan high to low, last hit overrides
  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    sel_wait = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (!SEL[i]) begin
        sel_hit  = 1'b1;
        sel_idx  = CH_W'(i);
        sel_wait = waits_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (!AS20 && sel_hit) begin
          state_d = ST_COUNT;
          ch_d    = sel_idx;
          cnt_d   = sel_wait;
        end
      end
      ST_COUNT: begin
        if (AS20) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else if (IDEWAIT) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_HOLD;
          tmo_d   = '0;
        end
      end
      ST_HOLD: begin
        if (AS20) begin
          state_d = ST_IDLE;
        end else if (IDEWAIT) begin
          state_d = ST_ACK;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_LAST) state_d = ST_ERR;
        end
      end
      ST_ACK, ST_ERR: begin
        if (AS20) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear right after the edge
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      ch_q    <= '0;
      dsack_q <= 1'b1;
      berr_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ch_q    <= ch_d;
      dsack_q <= (state_d != ST_ACK);
      berr_q  <= (state_d != ST_ERR);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Out-of-range CFG_CH matches no entry and is dropped
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(CHANNELS); i++) waits_q[i] <= WAIT_W'(DEFAULT_WAITS);
    end else if (CFG_WE) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (CFG_CH == CH_W'(i)) waits_q[i] <= CFG_DATA;
      end
    end
  end

  assign DSACK1 = dsack_q;
  assign BERR   = berr_q;
  assign BUSY   = busy_q;
  assign CH     = ch_q;

endmodule
